tm1638_ctrl: RTL

Transaction scheduler for the TM1638 LED/key board. Keeps a 16-byte display shadow RAM and a brightness/enable setting, and sequences the `spi` transaction engine. It issues the mode command, per-address display writes, display control and periodic key scans. It sits between the board application logic and `spi`, and is the only master of the `spi` input handshake.

---
 rtl/tm1638_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tm1638_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tm1638_ctrl
//  Description : TM1638 transaction scheduler. Holds the display shadow RAM
//                and settings and issues mode, data, control and key-scan
//                words to the spi engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tm1638_ctrl #(
    parameter int SCAN_PERIOD = 250000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Wr_En,
    input  logic [3:0]  i_Wr_Addr,
    input  logic [7:0]  i_Wr_Data,
    input  logic [2:0]  i_Bright,
    input  logic        i_Disp_On,
    output logic        o_Spi_Data_Ready,
    output logic [17:0] o_Spi_Data,
    input  logic        i_Spi_Busy,
    input  logic [31:0] i_Spi_Rx,
    output logic [7:0]  o_Keys,
    output logic [31:0] o_Keys_Raw,
    output logic        o_Keys_Valid,
    output logic        o_Idle
);
    localparam int               CNT_W    = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       ram_q [16];
    logic [7:0]       ram_d [16];
    logic [15:0]      dirty_q, dirty_d;
    logic             mode_pend_q, mode_pend_d;
    logic             ctrl_pend_q, ctrl_pend_d;
    logic             scan_pend_q, scan_pend_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [3:0]       ctrl_copy_q, ctrl_copy_d;
    logic [17:0]      word_q, word_d;
    logic [7:0]       keys_q, keys_d;
    logic [31:0]      keys_raw_q, keys_raw_d;
    logic             keys_valid_q, keys_valid_d;

    logic             dirty_any;
    logic [3:0]       dirty_addr;
    logic             scan_wrap;
    logic             any_pend;

    // Descending scan so the lowest dirty address is the one left standing
    always_comb begin
        dirty_any  = 1'b0;
        dirty_addr = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (dirty_q[i]) begin
                dirty_any  = 1'b1;
                dirty_addr = 4'(i);
            end
        end
    end

    assign scan_wrap = (scan_cnt_q == CNT_LAST);
    assign any_pend  = mode_pend_q | dirty_any | ctrl_pend_q | scan_pend_q;

    always_comb begin
        state_d      = state_q;
        ram_d        = ram_q;
        dirty_d      = dirty_q;
        mode_pend_d  = mode_pend_q;
        ctrl_pend_d  = ctrl_pend_q;
        scan_pend_d  = scan_pend_q;
        word_d       = word_q;
        keys_d       = keys_q;
        keys_raw_d   = keys_raw_q;
        keys_valid_d = 1'b0;
        ctrl_copy_d  = {i_Disp_On, i_Bright};
        scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (any_pend && !i_Spi_Busy) begin
                    state_d = S_ISSUE;
                    if (mode_pend_q) begin
                        word_d      = {2'b00, 8'h00, 8'h44};
                        mode_pend_d = 1'b0;
                    end else if (dirty_any) begin
                        word_d              = {2'b01, ram_q[dirty_addr], 4'hC, dirty_addr};
                        dirty_d[dirty_addr] = 1'b0;
                    end else if (ctrl_pend_q) begin
                        word_d      = {2'b00, 8'h00, (i_Disp_On ? {5'b10001, i_Bright} : 8'h80)};
                        ctrl_pend_d = 1'b0;
                    end else begin
                        word_d      = {2'b10, 8'h00, 8'h42};
                        scan_pend_d = 1'b0;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT_START;
            S_WAIT_START: begin
                if (i_Spi_Busy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!i_Spi_Busy) begin
                    state_d = S_IDLE;
                    if (word_q[17]) begin
                        keys_raw_d   = i_Spi_Rx;
                        keys_valid_d = 1'b1;
                        // A key read leaves the chip in read mode
                        mode_pend_d  = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            keys_d[k]     = i_Spi_Rx[8*k];
                            keys_d[k + 4] = i_Spi_Rx[8*k + 4];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Sets are applied after the issue clears so a same-cycle set wins
        if (i_Wr_En) begin
            ram_d[i_Wr_Addr]   = i_Wr_Data;
            dirty_d[i_Wr_Addr] = 1'b1;
        end
        if ({i_Disp_On, i_Bright} != ctrl_copy_q) ctrl_pend_d = 1'b1;
        if (scan_wrap) scan_pend_d = 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
            dirty_q      <= 16'hFFFF;
            mode_pend_q  <= 1'b1;
            ctrl_pend_q  <= 1'b1;
            scan_pend_q  <= 1'b0;
            scan_cnt_q   <= '0;
            ctrl_copy_q  <= 4'd0;
            word_q       <= 18'd0;
            keys_q       <= 8'd0;
            keys_raw_q   <= 32'd0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_q        <= ram_d;
            dirty_q      <= dirty_d;
            mode_pend_q  <= mode_pend_d;
            ctrl_pend_q  <= ctrl_pend_d;
            scan_pend_q  <= scan_pend_d;
            scan_cnt_q   <= scan_cnt_d;
            ctrl_copy_q  <= ctrl_copy_d;
            word_q       <= word_d;
            keys_q       <= keys_d;
            keys_raw_q   <= keys_raw_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    assign o_Spi_Data_Ready = (state_q == S_ISSUE);
    assign o_Spi_Data       = word_q;
    assign o_Keys           = keys_q;
    assign o_Keys_Raw       = keys_raw_q;
    assign o_Keys_Valid     = keys_valid_q;
    assign o_Idle           = (state_q == S_IDLE) && !any_pend;

endmodule
`default_nettype wire
